sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
Per-scanline sprite engine sitting directly downstream of the hsync/vsync timing generator; it consumes hpos/vpos/display_on and produces a 1-bit sprite pixel stream for the colour mux.
During each horizontal blank it decides whether the sprite overlaps the next line and fetches that bitmap row from an external synchronous ROM. On the next line it shifts the row out, one pixel per clock, starting at the sprite X position.

Parameters:
SPRITE_W, 8, sprite width in pixels (= ROM data width)
SPRITE_H, 16, sprite height in lines
H_DISPLAY, 256, first non-visible hpos (hblank start)
V_TOTAL, 262, lines per frame (vpos wraps V_TOTAL-1 -> 0)
ROW_BITS, $clog2(SPRITE_H), ROM row-address width

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
hpos  in  9  current pixel column from timing generator
vpos  in  9  current line from timing generator
display_on  in  1  visible-area flag from timing generator
sprite_x  in  9  sprite left column; sampled in CHECK
sprite_y  in  9  sprite top line; sampled in CHECK
rom_addr  out  ROW_BITS  bitmap row index to ROM
rom_data  in  SPRITE_W  row bits, MSB = leftmost; valid one clock after rom_addr
gfx  out  1  sprite pixel on
in_progress  out  1  high while state is DRAW

Behaviour:
- Reset (async, active-high) forces the following on assertion, without waiting for a clock edge:
  - state=IDLE, rom_addr=0, shift_reg=0, pix_cnt=0, x_lat=0.
  - gfx=0 and in_progress=0.
- Derived value next_line = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- Derived value row = (next_line - sprite_y) mod 512, 9-bit wrap. This lets sprite_y near 511 show a partial sprite at the top of the frame.
- Global rule: on any clock edge with hpos==H_DISPLAY, the next state is CHECK regardless of the current state. This aborts a DRAW that is clipped at the right edge.
- State transitions:
  - IDLE: hold; go to CHECK on hpos==H_DISPLAY.
  - CHECK (1 clk): latch x_lat<=sprite_x. If row<SPRITE_H, then rom_addr<=row[ROW_BITS-1:0] and go to FETCH. Otherwise go to IDLE.
  - FETCH (1 clk): rom_addr held stable while the ROM access occurs; go to LATCH.
  - LATCH (1 clk): shift_reg<=rom_data, pix_cnt<=0; go to WAIT_X.
  - WAIT_X: on an edge with hpos==x_lat and x_lat<H_DISPLAY, go to DRAW. If x_lat>=H_DISPLAY the sprite is never drawn, and the state is left only via the global rule.
  - DRAW: on each edge, shift_reg<<=1 and pix_cnt++. After the edge where pix_cnt==SPRITE_W-1, go to IDLE.
- rom_addr holds its last value outside CHECK.
- Output gfx = (state==DRAW) & shift_reg[SPRITE_W-1] & display_on, combinational from registers.
- Latency: pixel k (k=0 is the MSB) appears while hpos == x_lat+1+k. The colour mux accounts for this 1-pixel offset.
- Fetch budget: the fetch completes by hpos=H_DISPLAY+3, well inside hblank.
- sprite_x/sprite_y changes after CHECK have no effect until the next line's CHECK.
- Reset mid-line: no pixels are output until a full CHECK/FETCH has completed after reset release.

Test Plan:
- Basic draw: sprite_x=100, sprite_y=50, every ROM row 8'hA5.
  - Line 49 hblank: rom_addr=0 during FETCH.
  - Line 50: gfx = 1,0,1,0,0,1,0,1 at hpos 101..108; gfx=0 at all other hpos.
- Vertical bounds: sprite_y=50, ROM row r = r.
  - rom_addr=15 fetched in line 64 hblank.
  - gfx never 1 on lines 49 or 66.
  - in_progress pulses for exactly 8 clocks on lines 50..65.
- Frame wrap: sprite_y=0.
  - Fetch occurs in the hblank of vpos=261 with rom_addr=0.
  - Row 0 is drawn on line 0.
  - sprite_y=510 draws row 2 on line 0.
- Right clip: sprite_x=252, data 8'hFF.
  - gfx=1 at hpos 253..255, gfx=0 from hpos 256 (display_on low).
  - State is CHECK on the edge after hpos==256.
- Off-screen X: sprite_x=300 → gfx stays 0 and state stays in WAIT_X until the next hpos==256.
- Reset mid-DRAW: assert reset at hpos=103.
  - gfx=0 and in_progress=0 immediately, without waiting for a clock edge.
  - Release reset on the same line: gfx stays 0 for the rest of that line.
  - Normal drawing resumes on the following line.

Source files
------------

// File: rtl/sprite_renderer.sv
// Per-scanline sprite engine: during hblank it checks whether the sprite
// covers the next line and fetches that bitmap row from a synchronous ROM.
// On the following line it shifts the row out one pixel per clock, starting
// one pixel after hpos reaches the latched sprite X position.
module sprite_renderer #(
    parameter int SPRITE_W  = 8,
    parameter int SPRITE_H  = 16,
    parameter int H_DISPLAY = 256,
    parameter int V_TOTAL   = 262,
    parameter int ROW_BITS  = $clog2(SPRITE_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          hpos,
    input  logic [8:0]          vpos,
    input  logic                display_on,
    input  logic [8:0]          sprite_x,
    input  logic [8:0]          sprite_y,
    output logic [ROW_BITS-1:0] rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    output logic                gfx,
    output logic                in_progress
);

    localparam int CNT_BITS = $clog2(SPRITE_W);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(SPRITE_W - 1);
    localparam logic [8:0] HBLANK_START = 9'(H_DISPLAY);
    localparam logic [8:0] LAST_LINE    = 9'(V_TOTAL - 1);
    localparam logic [8:0] HEIGHT       = 9'(SPRITE_H);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_FETCH  = 3'd2,
        S_LATCH  = 3'd3,
        S_WAIT_X = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   rom_addr_q, rom_addr_d;
    logic [SPRITE_W-1:0]   shift_q, shift_d;
    logic [CNT_BITS-1:0]   pix_cnt_q, pix_cnt_d;
    logic [8:0]            x_lat_q, x_lat_d;

    logic [8:0]            next_line_s;
    logic [8:0]            row_s;
    logic                  hblank_edge_s;

    // Line-relative helpers: the row of the sprite that falls on the next line
    // (9-bit wrap lets a sprite starting near line 511 appear at frame top).
    always_comb begin
        next_line_s   = (vpos == LAST_LINE) ? 9'd0 : (vpos + 9'd1);
        row_s         = next_line_s - sprite_y;
        hblank_edge_s = (hpos == HBLANK_START);
    end

    // Next-state and datapath update; hblank start always restarts the
    // sequence, which also aborts a draw clipped at the right edge.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        shift_d    = shift_q;
        pix_cnt_d  = pix_cnt_q;
        x_lat_d    = x_lat_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_CHECK: begin
                x_lat_d = sprite_x;
                if (row_s < HEIGHT) begin
                    rom_addr_d = row_s[ROW_BITS-1:0];
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shift_d   = rom_data;
                pix_cnt_d = '0;
                state_d   = S_WAIT_X;
            end
            S_WAIT_X: begin
                if ((hpos == x_lat_q) && (x_lat_q < HBLANK_START)) begin
                    state_d = S_DRAW;
                end else begin
                    state_d = S_WAIT_X;
                end
            end
            S_DRAW: begin
                shift_d   = {shift_q[SPRITE_W-2:0], 1'b0};
                pix_cnt_d = pix_cnt_q + CNT_BITS'(1);
                if (pix_cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (hblank_edge_s) begin
            state_d = S_CHECK;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            shift_q    <= '0;
            pix_cnt_q  <= '0;
            x_lat_q    <= 9'd0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            shift_q    <= shift_d;
            pix_cnt_q  <= pix_cnt_d;
            x_lat_q    <= x_lat_d;
        end
    end

    // Outputs decoded from registers only, so reset clears them immediately.
    always_comb begin
        rom_addr    = rom_addr_q;
        in_progress = (state_q == S_DRAW);
        gfx         = (state_q == S_DRAW) & shift_q[SPRITE_W-1] & display_on;
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: drives a shortened-line timing generator, models
// the ROM, and checks each line against a line-level reference model, plus a
// table of fixed scenarios and hand-written reset / late-update sequences.
module tb_sprite_renderer;

    localparam int H_TOTAL   = 280;
    localparam int H_DISPLAY = 256;
    localparam int V_TOTAL   = 262;

    logic       clk;
    logic       reset;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic [8:0] sprite_x;
    logic [8:0] sprite_y;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       gfx;
    logic       in_progress;

    logic [7:0] rom_mem [16];

    int errors = 0;
    int checks = 0;

    // reference-model record: what the previous hblank should have fetched
    bit         rec_draw = 1'b0;
    int         rec_x    = 0;
    logic [7:0] rec_bits = 8'h00;

    logic [H_TOTAL-1:0] act_line;
    int                 last_ip;
    int                 last_addr;

    sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .gfx        (gfx),
        .in_progress(in_progress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM: data valid one clock after the address
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fill_rom(input int mode, input logic [7:0] fill);
        for (int r = 0; r < 16; r++) begin
            case (mode)
                0:       rom_mem[r] = fill;
                1:       rom_mem[r] = 8'(r);
                2:       rom_mem[r] = 8'hC0 | 8'(r);
                default: rom_mem[r] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    function automatic logic [7:0] grab(input int sx);
        logic [7:0] res;
        res = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (sx + 1 + k < H_TOTAL) res[7-k] = act_line[sx+1+k];
        end
        return res;
    endfunction

    // Run one full line on vpos v. rst_at/rst_rel: hpos at which reset is
    // asserted/released (-1 = never). new_sx >= 0 changes sprite_x after CHECK.
    task automatic run_line(input int v, input int rst_at, input int rst_rel, input int new_sx);
        bit         cur_draw;
        int         cur_x;
        logic [7:0] cur_bits;
        logic [H_TOTAL-1:0] exp_line;
        int  exp_ip;
        int  ip_cnt;
        bit  fetch_now;
        int  row_now;
        int  nl;
        cur_draw  = rec_draw;
        cur_x     = rec_x;
        cur_bits  = rec_bits;
        exp_line  = '0;
        act_line  = '0;
        exp_ip    = 0;
        ip_cnt    = 0;
        fetch_now = 1'b0;
        row_now   = 0;
        for (int h = 0; h < H_TOTAL; h++) begin
            hpos       = 9'(h);
            vpos       = 9'(v);
            display_on = (h < H_DISPLAY);
            if (h == H_DISPLAY) begin
                nl        = (v == V_TOTAL - 1) ? 0 : v + 1;
                row_now   = (nl - int'(sprite_y) + 512) % 512;
                fetch_now = (row_now < 16);
                rec_draw  = fetch_now && (int'(sprite_x) < H_DISPLAY);
                rec_x     = int'(sprite_x);
                rec_bits  = fetch_now ? rom_mem[row_now] : 8'h00;
            end
            if (h == 258 && new_sx >= 0) sprite_x = 9'(new_sx);
            if (h == rst_at) begin
                reset = 1'b1;
                #1;
                chk("reset_async_gfx", int'(gfx), 0);
                chk("reset_async_in_progress", int'(in_progress), 0);
                chk("reset_async_rom_addr", int'(rom_addr), 0);
                cur_draw = 1'b0;
            end
            if (h == rst_rel) reset = 1'b0;
            if (cur_draw && h >= cur_x + 1 && h <= cur_x + 8) begin
                if (h < H_DISPLAY) exp_line[h] = cur_bits[7-(h-cur_x-1)];
                if (h <= H_DISPLAY) exp_ip++;
            end
            @(negedge clk);
            act_line[h] = gfx;
            if (in_progress) ip_cnt++;
            if (h == 258) begin
                last_addr = int'(rom_addr);
                if (fetch_now) chk($sformatf("fetch_addr v=%0d", v), int'(rom_addr), row_now);
            end
            @(posedge clk);
            #1;
        end
        last_ip = ip_cnt;
        checks++;
        if (act_line !== exp_line) begin
            errors++;
            $display("FAIL gfx_line v=%0d: got %h expected %h", v, act_line, exp_line);
        end
        chk($sformatf("in_progress_clocks v=%0d", v), ip_cnt, exp_ip);
    endtask

    typedef struct {
        int         sx;
        int         sy;
        int         fv;
        int         mode;
        logic [7:0] fill;
        int         exp_addr;
        logic [7:0] exp_pix;
        int         exp_ip;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // sx, sy, fetch line, rom mode, fill, expected addr (-1 skip), pixels, in_progress clocks
        vecs[0] = '{100,  50,  49, 0, 8'hA5,  0, 8'hA5, 8};   // basic draw
        vecs[1] = '{100,  50,  64, 1, 8'h00, 15, 8'h0F, 8};   // last sprite row
        vecs[2] = '{100,  50,  65, 1, 8'h00, -1, 8'h00, 0};   // line 66: below sprite
        vecs[3] = '{100,  50,  48, 1, 8'h00, -1, 8'h00, 0};   // line 49: above sprite
        vecs[4] = '{ 10,   0, 261, 2, 8'h00,  0, 8'hC0, 8};   // frame wrap, row 0 on line 0
        vecs[5] = '{ 10, 510, 261, 2, 8'h00,  2, 8'hC2, 8};   // sprite_y=510 -> row 2 on line 0
        vecs[6] = '{252,  50,  50, 0, 8'hFF,  1, 8'hE0, 4};   // right clip
        vecs[7] = '{300,  50,  55, 0, 8'hFF,  6, 8'h00, 0};   // off-screen X
        vecs[8] = '{  0,  50,  51, 1, 8'h00,  2, 8'h02, 8};   // left edge
        vecs[9] = '{255,  50,  52, 0, 8'hFF,  3, 8'h00, 1};   // one pixel, in hblank

        reset      = 1'b1;
        hpos       = 9'd0;
        vpos       = 9'd0;
        display_on = 1'b1;
        sprite_x   = 9'd0;
        sprite_y   = 9'd0;
        fill_rom(0, 8'hFF);
        #2;
        chk("reset_gfx", int'(gfx), 0);
        chk("reset_in_progress", int'(in_progress), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // table-driven scenarios: fetch line, then draw line
        for (int i = 0; i < 10; i++) begin
            int nv;
            sprite_x = 9'(vecs[i].sx);
            sprite_y = 9'(vecs[i].sy);
            fill_rom(vecs[i].mode, vecs[i].fill);
            run_line(vecs[i].fv, -1, -1, -1);
            if (vecs[i].exp_addr >= 0) chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].exp_addr);
            nv = (vecs[i].fv == V_TOTAL - 1) ? 0 : vecs[i].fv + 1;
            run_line(nv, -1, -1, -1);
            chk($sformatf("vec%0d_pixels", i), int'(grab(vecs[i].sx)), int'(vecs[i].exp_pix));
            chk($sformatf("vec%0d_in_progress", i), last_ip, vecs[i].exp_ip);
        end

        // vertical sweep across the whole sprite
        sprite_x = 9'd100;
        sprite_y = 9'd50;
        fill_rom(1, 8'h00);
        for (int v = 47; v <= 67; v++) run_line(v, -1, -1, -1);

        // reset in the middle of a draw, released on the same line
        sprite_x = 9'd100;
        sprite_y = 9'd50;
        fill_rom(0, 8'hA5);
        run_line(49, -1, -1, -1);
        run_line(50, 103, 110, -1);
        chk("reset_line_in_progress", last_ip, 2);
        chk("reset_line_tail", int'(grab(102)), 0);
        run_line(51, -1, -1, -1);
        chk("after_reset_pixels", int'(grab(100)), 8'hA5);

        // sprite_x changed after CHECK only takes effect a line later
        run_line(52, -1, -1, 40);
        run_line(53, -1, -1, -1);
        chk("late_sx_old_pos", int'(grab(100)), 8'hA5);
        chk("late_sx_new_pos_idle", int'(grab(40)), 0);
        run_line(54, -1, -1, -1);
        chk("late_sx_new_pos", int'(grab(40)), 8'hA5);

        // randomized lines against the model
        for (int it = 0; it < 30; it++) begin
            int v;
            v = $urandom_range(0, V_TOTAL - 1);
            sprite_x = 9'($urandom_range(0, 319));
            if ($urandom_range(0, 3) == 0) sprite_y = 9'($urandom_range(0, 511));
            else sprite_y = 9'((v + 1 - int'($urandom_range(0, 20)) + 512) % 512);
            fill_rom(3, 8'h00);
            run_line(v, -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
